// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared FSM states and default timing constants for the UART
//               transmit feeder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } feeder_state_e;

  localparam int CLKS_PER_BIT = 434;
  localparam int FRAME_BITS   = 11;

  // Round up to a power of two so the timeout has margin over one full frame.
  function automatic int pow2_ceil(input int n);
    return 1 << $clog2(n);
  endfunction

  localparam int DEFAULT_TIMEOUT = pow2_ceil(FRAME_BITS * CLKS_PER_BIT);
  localparam int DEFAULT_TO_W    = $clog2(DEFAULT_TIMEOUT) + 1;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
//==============================================================================
// Module      : uart_byte_fifo
// Description : Synchronous first-word-fall-through byte FIFO with registered
//               occupancy count and full/empty flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_byte_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [7:0]        din_i,
  input  logic              rd_en_i,
  output logic [7:0]        dout_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [ADDR_W:0] c_FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              wr_ok;
  logic              rd_ok;

  assign full_o  = (count_q == c_FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A full FIFO drops the write even when a pop happens on the same edge.
  assign wr_ok = wr_en_i & ~full_o;
  assign rd_ok = rd_en_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
//==============================================================================
// Module      : uart_tx_feeder
// Description : Buffers bytes and launches them one at a time into a UART
//               transmitter, pacing on its done pulse with a timeout escape.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = DEFAULT_TO_W
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Done,
  output logic              o_Busy,
  output logic              o_Timeout
);

  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

  feeder_state_e   state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            tx_dv_q, tx_dv_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            timeout_q, timeout_d;
  logic            overflow_q;
  logic            fifo_pop;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .wr_en_i (i_Wr_DV),
    .din_i   (i_Wr_Byte),
    .rd_en_i (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (o_Count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      to_cnt_q   <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_q | (i_Wr_DV & fifo_full);
    end
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    timeout_d = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          tx_byte_d = fifo_dout;
          tx_dv_d   = 1'b1;
          to_cnt_d  = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Done wins over timeout when both land on the same edge.
        if (i_Tx_Done) begin
          state_d = ST_IDLE;
        end else if (to_cnt_q == c_TO_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_Full     = fifo_full;
  assign o_Empty    = fifo_empty;
  assign o_Overflow = overflow_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Busy     = (state_q == ST_WAIT);
  assign o_Timeout  = timeout_q;

endmodule

`default_nettype wire
